// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer:
// FSM state codes, funct3 decodes, ALU operation codes and operand-sign helpers.
package muldiv_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Same encodings the alu_control decode produces for R-type add/sub.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide for the EX stage: one add or subtract per
// cycle on the shared ALU, shift-add multiply and restoring divide.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  input  logic                     flush,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     busy,
  output logic                     alu_grant,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  logic [2:0]            r_state;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_acc;     // multiply: hi word; divide: partial remainder
  logic [DATA_WIDTH-1:0] r_lo;      // multiply: lo word; divide: dividend/quotient
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_neg;
  logic [4:0]            r_count;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_is_div;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic                  w_res_neg;
  logic [DATA_WIDTH-1:0] w_mag_a;
  logic [DATA_WIDTH-1:0] w_mag_b;
  logic                  w_div_zero;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_new_hi;
  logic                  w_carry;
  logic [DATA_WIDTH:0]   w_r_sh;
  logic                  w_ge;
  logic [2*DATA_WIDTH-1:0] w_prod_neg;
  logic [DATA_WIDTH-1:0] w_fix_res;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_is_div   = r_funct3[2];
    w_a_neg    = is_signed_a(r_funct3) & r_lo[31];
    w_b_neg    = is_signed_b(r_funct3) & r_b[31];
    w_res_neg  = (r_funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_mag_a    = w_a_neg ? -r_lo : r_lo;
    w_mag_b    = w_b_neg ? -r_b : r_b;
    w_div_zero = w_is_div && (r_b == '0);
    w_ovf      = ((r_funct3 == F3_DIV) || (r_funct3 == F3_REM)) &&
                 (r_lo == 32'h8000_0000) && (r_b == '1);

    w_new_hi   = r_lo[0] ? alu_result : r_acc;
    w_carry    = r_lo[0] & (alu_result < r_acc);
    w_r_sh     = {r_acc, r_lo[31]};
    w_ge       = w_r_sh[32] | (w_r_sh[31:0] >= r_b);

    w_prod_neg = -{r_acc, r_lo};
    w_fix_res  = '0;
    case (r_funct3)
      F3_MUL:                       w_fix_res = r_neg ? w_prod_neg[31:0]  : r_lo;
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = r_neg ? w_prod_neg[63:32] : r_acc;
      F3_DIV, F3_DIVU:              w_fix_res = r_neg ? -r_lo  : r_lo;
      F3_REM, F3_REMU:              w_fix_res = r_neg ? -r_acc : r_acc;
      default:                      w_fix_res = '0;
    endcase
  end

  assign start_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;
  assign alu_grant    = (r_state == S_ITER);
  assign alu_srca      = alu_grant ? (w_is_div ? w_r_sh[31:0] : r_acc) : '0;
  assign alu_srcb      = alu_grant ? r_b : '0;
  assign alu_operation = alu_grant ? (w_is_div ? ALU_SUB : ALU_ADD) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_funct3 <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_funct3 <= funct3;
            r_lo     <= op_a;
            r_b      <= op_b;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          r_count <= '0;
          r_neg   <= 1'b0;
          // Special cases skip ITER but still pass through FIX to DONE.
          if (w_div_zero) begin
            r_lo    <= '1;
            r_acc   <= r_lo;
            r_state <= S_FIX;
          end else if (w_ovf) begin
            r_lo    <= 32'h8000_0000;
            r_acc   <= '0;
            r_state <= S_FIX;
          end else begin
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
            r_acc   <= '0;
            r_neg   <= w_res_neg;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (w_is_div) begin
            r_acc <= w_ge ? alu_result : w_r_sh[31:0];
            r_lo  <= {r_lo[30:0], w_ge};
          end else begin
            r_acc <= {w_carry, w_new_hi[31:1]};
            r_lo  <= {w_new_hi[0], r_lo[31:1]};
          end
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (result_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of RV32M vectors with hand-computed
// results and latencies, plus back-pressure, flush and reset sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;
  logic        alu_grant;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .funct3        (funct3),
    .op_a          (op_a),
    .op_b          (op_b),
    .flush         (flush),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result        (result),
    .busy          (busy),
    .alu_grant     (alu_grant),
    .alu_srca      (alu_srca),
    .alu_srcb      (alu_srcb),
    .alu_operation (alu_operation),
    .alu_result    (alu_result)
  );

  // Reference model of the shared EX-stage ALU.
  always_comb begin
    case (alu_operation)
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0110: alu_result = alu_srca - alu_srcb;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3      = f3;
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int gr);
    cyc = 0;
    gr  = 0;
    while (!result_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (alu_grant) gr++;
    end
    if (!result_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: result_valid not seen within %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int cyc;
    int gr;
    issue(v.f3, v.a, v.b);
    wait_done(cyc, gr);
    check({tag, " result"}, result, v.exp);
    check({tag, " latency"}, cyc, v.lat);
    check({tag, " grant cycles"}, gr, (v.lat == 34) ? 32 : 0);
    @(posedge clk);
    #1;
    check({tag, " start_ready after"}, start_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34}; // MUL 7*-3
    vecs[1]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34}; // MULH 7*-3
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34}; // MULHU
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34}; // MULHSU -1*2
    vecs[4]  = '{3'b000, 32'd1000,       32'd1000,      32'd1000000,   34}; // MUL
    vecs[5]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34}; // DIV -7/2
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34}; // REM -7/2
    vecs[7]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34}; // DIVU
    vecs[8]  = '{3'b101, 32'd100,        32'd7,         32'd14,        34}; // DIVU 100/7
    vecs[9]  = '{3'b111, 32'd100,        32'd7,         32'd2,         34}; // REMU 100/7
    vecs[10] = '{3'b100, 32'h8000_0000,  32'd2,         32'hC000_0000, 34}; // DIV min/2
    vecs[11] = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};  // DIVU 5/0
    vecs[12] = '{3'b110, 32'd5,          32'd0,         32'd5,         2};  // REM 5/0
    vecs[13] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};  // DIV overflow
    vecs[14] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};  // REM overflow
    vecs[15] = '{3'b111, 32'h8000_0000,  32'd0,         32'h8000_0000, 2};  // REMU x/0

    reset        = 1'b0;
    start_valid  = 1'b0;
    funct3       = 3'b000;
    op_a         = 32'h0;
    op_b         = 32'h0;
    flush        = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset start_ready", start_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset result_valid", result_valid, 1'b0);
    check("reset result", result, 32'h0);
    check("reset alu_grant", alu_grant, 1'b0);
    check("reset alu_operation", alu_operation, 4'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: result and flags hold while the consumer stalls.
    begin
      int cyc;
      int gr;
      result_ready = 1'b0;
      issue(3'b000, 32'd6, 32'd7);
      wait_done(cyc, gr);
      for (int k = 0; k < 10; k++) begin
        check("hold result", result, 32'd42);
        check("hold result_valid", result_valid, 1'b1);
        check("hold start_ready", start_ready, 1'b0);
        check("hold alu_srca", alu_srca, 32'h0);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release start_ready", start_ready, 1'b1);
      check("release result_valid", result_valid, 1'b0);
    end

    // Flush at iteration count 15.
    begin
      logic saw_valid;
      saw_valid = 1'b0;
      issue(3'b000, 32'd3, 32'd4);
      for (int k = 0; k < 16; k++) begin
        @(posedge clk);
        #1;
        saw_valid |= result_valid;
      end
      check("pre-flush alu_grant", alu_grant, 1'b1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      saw_valid |= result_valid;
      check("flush start_ready", start_ready, 1'b1);
      check("flush busy", busy, 1'b0);
      check("flush alu_grant", alu_grant, 1'b0);
      check("flush no result_valid", saw_valid, 1'b0);
    end

    // A start coinciding with flush in IDLE is dropped.
    @(negedge clk);
    funct3      = 3'b000;
    op_a        = 32'd9;
    op_b        = 32'd9;
    start_valid = 1'b1;
    flush       = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    flush       = 1'b0;
    check("flush+start busy", busy, 1'b0);
    check("flush+start start_ready", start_ready, 1'b1);

    run_op("mul after flush", '{3'b000, 32'd3, 32'd4, 32'd12, 34});

    // Asynchronous reset in the middle of ITER.
    begin
      logic saw_valid;
      saw_valid = 1'b0;
      issue(3'b100, 32'd1000, 32'd3);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        saw_valid |= result_valid;
      end
      #2;
      reset = 1'b0;
      #1;
      check("reset-mid busy", busy, 1'b0);
      check("reset-mid start_ready", start_ready, 1'b1);
      check("reset-mid alu_grant", alu_grant, 1'b0);
      check("reset-mid result", result, 32'h0);
      check("reset-mid no result_valid", saw_valid | result_valid, 1'b0);
      @(negedge clk);
      reset = 1'b1;
    end

    run_op("mul after reset", '{3'b000, 32'd3, 32'd4, 32'd12, 34});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
